// File: rtl/gemm_pkg.sv
// Shared definitions for the 16x16 GEMM core and its upstream loader.
//
// Contents:
//   DIM, N_ELEM        matrix dimension and elements per matrix
//   DATA_W, MUL_W      element width on the stream and the core's multiplier width
//   SUM_W              width of the core's accumulated sum
//   WR_SEL_M1/M2       core write-port matrix selects
//   loader_state_t     loader FSM states
//   in_mul_range()     true when an element survives truncation to MUL_W bits
package gemm_pkg;

   localparam int DIM    = 16;
   localparam int N_ELEM = 256;
   localparam int DATA_W = 21;
   localparam int MUL_W  = 14;
   localparam int SUM_W  = 32;

   localparam logic [1:0] WR_SEL_M1 = 2'd0;
   localparam logic [1:0] WR_SEL_M2 = 2'd1;

   typedef enum logic [2:0] {
      LOAD,
      FILL,
      START,
      WAIT,
      OUT
   } loader_state_t;

   // The core keeps only the low MUL_W bits of each operand. The value is
   // unchanged by that truncation exactly when every bit from the MUL_W-1
   // sign position upward agrees.
   function automatic logic in_mul_range(input logic [DATA_W-1:0] data);
      logic [DATA_W-MUL_W:0] top;
      top = data[DATA_W-1:MUL_W-1];
      return (top == '0) || (top == '1);
   endfunction

endpackage

// File: rtl/gemm_loader.sv
// Upstream feeder for the 16x16 GEMM core.
//
// Takes one job as a stream of 2*N_ELEM signed elements (M1 row-major, then
// M2 row-major), writes them into the core, pulses core_start, waits for
// core_done and returns the core's sum on a result port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_valid/s_ready     element stream handshake; s_data element, s_last end of job
//   core_wr_*           registered write port into the core (sel 0 = M1, 1 = M2)
//   core_start          one-cycle start pulse to the core
//   core_done/core_sum  core completion level and result
//   r_valid/r_ready     result handshake; r_sum plus error flags
//   r_range_err         some element lies outside the core's multiplier range
//   r_len_err           s_last missing on the final beat, or arrived early
//   r_timeout           core did not finish within TIMEOUT_CYC cycles
//   busy                a job is in progress
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload until that edge; ready may
// depend on state but never on the partner's valid.
module gemm_loader
   import gemm_pkg::*;
#(
   parameter int TIMEOUT_CYC = 8192
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              core_wr_en,
   output logic [1:0]        core_wr_sel,
   output logic [7:0]        core_wr_addr,
   output logic [DATA_W-1:0] core_wr_data,
   output logic              core_start,
   input  logic              core_done,
   input  logic [SUM_W-1:0]  core_sum,
   output logic              r_valid,
   input  logic              r_ready,
   output logic [SUM_W-1:0]  r_sum,
   output logic              r_range_err,
   output logic              r_len_err,
   output logic              r_timeout,
   output logic              busy
);

   localparam logic [8:0]  CNT_LAST = 9'd511;
   localparam logic [12:0] TMO_LAST = 13'(TIMEOUT_CYC - 1);

   loader_state_t     state, state_n;
   logic [8:0]        cnt, cnt_n;
   logic [12:0]       tmo_cnt, tmo_n;
   logic              range_err, range_err_n;
   logic              len_err, len_err_n;
   logic              timeout, timeout_n;
   logic [SUM_W-1:0]  sum_q, sum_n;
   logic              wr_en_n;
   logic [1:0]        wr_sel_n;
   logic [7:0]        wr_addr_n;
   logic [DATA_W-1:0] wr_data_n;
   logic              start_n;
   logic              accept;

   // Held low during reset so every output reads 0 while rst is asserted.
   assign s_ready     = (state == LOAD) && !rst;
   assign accept      = s_valid && s_ready;
   assign r_valid     = (state == OUT);
   assign r_sum       = sum_q;
   assign r_range_err = range_err;
   assign r_len_err   = len_err;
   assign r_timeout   = timeout;
   assign busy        = (state != LOAD) || (cnt != '0);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      tmo_n       = tmo_cnt;
      range_err_n = range_err;
      len_err_n   = len_err;
      timeout_n   = timeout;
      sum_n       = sum_q;
      wr_en_n     = 1'b0;
      wr_sel_n    = WR_SEL_M1;
      wr_addr_n   = '0;
      wr_data_n   = '0;
      start_n     = 1'b0;

      case (state)
         LOAD: begin
            if (accept) begin
               wr_en_n   = 1'b1;
               wr_sel_n  = cnt[8] ? WR_SEL_M2 : WR_SEL_M1;
               wr_addr_n = cnt[7:0];
               wr_data_n = s_data;
               cnt_n     = cnt + 9'd1;
               if (!in_mul_range(s_data)) range_err_n = 1'b1;
               if (cnt == CNT_LAST) begin
                  // Beat 511 always closes the job; a missing s_last means
                  // the producer's framing is off, the next beat starts a new job.
                  state_n = START;
                  if (!s_last) len_err_n = 1'b1;
               end else if (s_last) begin
                  len_err_n = 1'b1;
                  state_n   = FILL;
               end
            end
         end

         FILL: begin
            wr_en_n   = 1'b1;
            wr_sel_n  = cnt[8] ? WR_SEL_M2 : WR_SEL_M1;
            wr_addr_n = cnt[7:0];
            cnt_n     = cnt + 9'd1;
            if (cnt == CNT_LAST) state_n = START;
         end

         START: begin
            // core_start is registered, so it appears one cycle after the
            // final write and never overlaps a write strobe.
            start_n = 1'b1;
            tmo_n   = '0;
            state_n = WAIT;
         end

         WAIT: begin
            // During the start-pulse cycle core_done may still be the previous
            // job's level; the core clears it on the edge that sees start.
            if (core_done && !core_start) begin
               sum_n   = core_sum;
               state_n = OUT;
            end else if (tmo_cnt == TMO_LAST) begin
               timeout_n = 1'b1;
               sum_n     = '0;
               state_n   = OUT;
            end else begin
               tmo_n = tmo_cnt + 13'd1;
            end
         end

         OUT: begin
            if (r_ready) begin
               cnt_n       = '0;
               range_err_n = 1'b0;
               len_err_n   = 1'b0;
               timeout_n   = 1'b0;
               state_n     = LOAD;
            end
         end

         default: state_n = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LOAD;
         cnt          <= '0;
         tmo_cnt      <= '0;
         range_err    <= 1'b0;
         len_err      <= 1'b0;
         timeout      <= 1'b0;
         sum_q        <= '0;
         core_wr_en   <= 1'b0;
         core_wr_sel  <= '0;
         core_wr_addr <= '0;
         core_wr_data <= '0;
         core_start   <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         tmo_cnt      <= tmo_n;
         range_err    <= range_err_n;
         len_err      <= len_err_n;
         timeout      <= timeout_n;
         sum_q        <= sum_n;
         core_wr_en   <= wr_en_n;
         core_wr_sel  <= wr_sel_n;
         core_wr_addr <= wr_addr_n;
         core_wr_data <= wr_data_n;
         core_start   <= start_n;
      end
   end

endmodule
